ac_motor_gate_dead_time: RTL and testbench
==========================================

AC_MOTOR_GATE_DEAD_TIME -- requirements
Module: ac_motor_gate_dead_time

Interface
REQ-001 SHALL have parameter DEAD_CYCLES, default 100, clk cycles with both switches of a leg off (1 us at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 8, dead-time counter width; DEAD_CYCLES SHALL satisfy 1 <= DEAD_CYCLES <= 2**CNT_W-1.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, bridge enable; low forces all gates off.
REQ-006 SHALL have port sector, input, 3, synced sector from vector control, valid 0..5.
REQ-007 SHALL have ports u0, u1, u2, u7, input, 1 each, active-vector strobes from vector control; expected one-hot.
REQ-008 SHALL have port fault_clr, input, 1, clears the latched fault (macro-dependent).
REQ-009 SHALL have ports gate_h and gate_l, output, 3 each, high-/low-side gate drives, bit 0 = phase A, bit 1 = B, bit 2 = C.
REQ-010 SHALL have port fault, output, 1, invalid sector or non-one-hot strobes detected.

Function
REQ-011 SHALL map strobes to a 3-bit desired leg state (1 = high side on): u0 -> 000, u7 -> 111.
REQ-012 SHALL use vector table V0..V5 = 100, 110, 010, 011, 001, 101 (bit order CBA reversed: A is MSB as written).
REQ-013 SHALL map u1 -> V[sector] and u2 -> V[(sector+1) mod 6]; sector 5 with u2 wraps to V0 = 100.
REQ-014 SHALL treat sector 6 or 7, or a strobe count other than exactly one, as invalid: fault asserted, desired state = all legs OFF.
REQ-015 SHALL run one FSM per leg with states OFF, DEAD, HIGH, LOW; outputs registered (gate_h = HIGH, gate_l = LOW).
REQ-016 SHALL, in HIGH or LOW, on a desired side different from the conducting one, enter DEAD at the same edge and load counter = DEAD_CYCLES-1.
REQ-017 SHALL, in DEAD, decrement each cycle and enter the desired side's state when counter = 0 at an edge, so the new gate rises exactly DEAD_CYCLES edges after the old one fell.
REQ-018 SHALL, when the desired side changes during DEAD, keep both gates off and reload the counter to DEAD_CYCLES-1.
REQ-019 SHALL, from OFF, go to DEAD with a full count once enable is high and the input is valid; never OFF->HIGH/LOW directly.
REQ-020 SHALL force every leg to OFF at the next edge when enable is low or desired is OFF; gates drop at that edge with no dead time.
REQ-021 SHALL never assert gate_h[i] and gate_l[i] in the same cycle under any input sequence.
REQ-022 SHALL leave a leg with unchanged desired side untouched (no glitch, no dead-time insertion).

Reset
REQ-023 SHALL, while reset_n is low, immediately drive gate_h = 000, gate_l = 000, and fault = 0, with all FSMs in OFF and counters at 0.
REQ-024 SHALL, on reset release mid-pattern, pass through a full DEAD interval before any gate turns on.

Configuration
REQ-025 SHALL, with AC_MOTOR_GATE_FAULT_LATCH_EN defined, latch fault on first invalid input and hold all legs OFF until fault_clr is high at an edge with valid input; legs then restart via DEAD.
REQ-026 SHALL, without AC_MOTOR_GATE_FAULT_LATCH_EN, assert fault only in cycles with invalid input, recover automatically, and ignore fault_clr.

Structure
REQ-027 SHALL take the vector table, sector encoding, and the leg-state encoding (OFF/DEAD/HIGH/LOW) from the shared include ac_motor_pkg.
REQ-028 SHALL implement the per-leg FSM and counter as sub-module ac_motor_dead_time_leg, instantiated three times.

Verification (DEAD_CYCLES = 4)
REQ-029 SHALL cover: reset release, enable = 1, u0 -> all gate_l rise 4 edges after the first valid edge; gate_h stays 000.
REQ-030 SHALL cover: sector 0, u0 -> u1 -> A: gate_l[0] falls at the edge, gate_h[0] rises 4 edges later; B and C stay unchanged.
REQ-031 SHALL cover: sector 5, u2 -> desired state 100 (wrap); the A leg goes high and B, C stay low.
REQ-032 SHALL cover: leg A in DEAD with count 2, desired reverts -> both gates of A stay off 4 more edges; overlap checker never fires.
REQ-033 SHALL cover: u1 = u2 = 1, or sector 7 -> fault = 1 and all gates are 0 at the next edge; latch holds until fault_clr, per the macro.
REQ-034 SHALL cover: enable dropped mid-DEAD -> all gates 0 at the next edge; re-enable goes through full DEAD.

Source files
------------

// File: rtl/ac_motor_pkg.sv
// Shared encodings for the gate dead-time block: leg FSM states, sector type,
// and the active-vector table in gate bit order (bit 0 = A, bit 1 = B, bit 2 = C).
package ac_motor_pkg;

  typedef enum logic [1:0] {
    LEG_OFF  = 2'd0,
    LEG_DEAD = 2'd1,
    LEG_HIGH = 2'd2,
    LEG_LOW  = 2'd3
  } leg_state_e;

  typedef logic [2:0] sector_t;

  localparam sector_t SECTOR_LAST = 3'd5;

  // Written as A-B-C (100 = A high) in the vector tables; stored here as {C,B,A}.
  function automatic logic [2:0] vec_of(input sector_t s);
    logic [2:0] v;
    v = 3'b000;
    case (s)
      3'd0:    v = 3'b001;
      3'd1:    v = 3'b011;
      3'd2:    v = 3'b010;
      3'd3:    v = 3'b110;
      3'd4:    v = 3'b100;
      3'd5:    v = 3'b101;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  function automatic sector_t sector_next(input sector_t s);
    return (s == SECTOR_LAST) ? 3'd0 : s + 3'd1;
  endfunction

endpackage

// File: rtl/ac_motor_dead_time_leg.sv
// One inverter leg: OFF/DEAD/HIGH/LOW FSM with a dead-time down-counter.
// Gate outputs are registered from the next state so they change cleanly at the edge.
module ac_motor_dead_time_leg
  import ac_motor_pkg::*;
#(
  parameter int DEAD_CYCLES = 100,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_run,
  input  logic i_high,
  output logic o_gate_h,
  output logic o_gate_l
);

  localparam logic [CNT_W-1:0] LP_RELOAD = CNT_W'(DEAD_CYCLES - 1);

  leg_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_tgt_high, w_tgt_nxt;
  logic             r_gate_h, r_gate_l;

  // NOTE: every combinational output is defaulted first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tgt_nxt   = r_tgt_high;
    if (!i_run) begin
      w_state_nxt = LEG_OFF;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        LEG_OFF: begin
          w_state_nxt = LEG_DEAD;
          w_cnt_nxt   = LP_RELOAD;
          w_tgt_nxt   = i_high;
        end
        LEG_HIGH: if (!i_high) begin
          w_state_nxt = LEG_DEAD;
          w_cnt_nxt   = LP_RELOAD;
          w_tgt_nxt   = 1'b0;
        end
        LEG_LOW: if (i_high) begin
          w_state_nxt = LEG_DEAD;
          w_cnt_nxt   = LP_RELOAD;
          w_tgt_nxt   = 1'b1;
        end
        LEG_DEAD: begin
          // A new target restarts the full interval so the gap is never shortened.
          if (i_high != r_tgt_high) begin
            w_cnt_nxt = LP_RELOAD;
            w_tgt_nxt = i_high;
          end else if (r_cnt == '0) begin
            w_state_nxt = r_tgt_high ? LEG_HIGH : LEG_LOW;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt = LEG_OFF;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= LEG_OFF;
      r_cnt      <= '0;
      r_tgt_high <= 1'b0;
      r_gate_h   <= 1'b0;
      r_gate_l   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tgt_high <= w_tgt_nxt;
      r_gate_h   <= (w_state_nxt == LEG_HIGH);
      r_gate_l   <= (w_state_nxt == LEG_LOW);
    end
  end

  assign o_gate_h = r_gate_h;
  assign o_gate_l = r_gate_l;

endmodule

// File: rtl/ac_motor_gate_dead_time.sv
// Three-leg gate driver with dead-time insertion from sector/strobe commands.
// Define AC_MOTOR_GATE_FAULT_LATCH_EN to latch faults until fault_clr with valid input.
module ac_motor_gate_dead_time
  import ac_motor_pkg::*;
#(
  parameter int DEAD_CYCLES = 100,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [2:0] sector,
  input  logic       u0,
  input  logic       u1,
  input  logic       u2,
  input  logic       u7,
  input  logic       fault_clr,
  output logic [2:0] gate_h,
  output logic [2:0] gate_l,
  output logic       fault
);

  logic       w_valid;
  logic       w_hold;
  logic       w_run;
  logic       w_fault_nxt;
  logic [2:0] w_desired;
  logic       r_fault;

  assign w_valid = ($countones({u0, u1, u2, u7}) == 1) && (sector <= SECTOR_LAST);

  always_comb begin
    w_desired = 3'b000;
    if (u7)      w_desired = 3'b111;
    else if (u1) w_desired = vec_of(sector);
    else if (u2) w_desired = vec_of(sector_next(sector));
  end

`ifdef AC_MOTOR_GATE_FAULT_LATCH_EN
  assign w_hold      = r_fault && !(fault_clr && w_valid);
  assign w_fault_nxt = !w_valid || w_hold;
`else
  logic w_unused_fault_clr;
  assign w_unused_fault_clr = fault_clr;
  assign w_hold      = 1'b0;
  assign w_fault_nxt = !w_valid;
`endif

  assign w_run = enable && w_valid && !w_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_fault <= 1'b0;
    else          r_fault <= w_fault_nxt;
  end

  assign fault = r_fault;

  for (genvar i = 0; i < 3; i++) begin : g_leg
    ac_motor_dead_time_leg #(
      .DEAD_CYCLES(DEAD_CYCLES),
      .CNT_W      (CNT_W)
    ) u_leg (
      .clk     (clk),
      .reset_n (reset_n),
      .i_run   (w_run),
      .i_high  (w_desired[i]),
      .o_gate_h(gate_h[i]),
      .o_gate_l(gate_l[i])
    );
  end

endmodule

// File: tb/tb_ac_motor_gate_dead_time.sv
// Scoreboard bench for ac_motor_gate_dead_time with DEAD_CYCLES = 4.
// Expected gate/fault values are queued per edge when stimulus is set, then popped each cycle.
module tb_ac_motor_gate_dead_time;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [2:0] sector;
  logic       u0, u1, u2, u7;
  logic       fault_clr;
  logic [2:0] gate_h, gate_l;
  logic       fault;

  typedef struct {
    logic [2:0] gh;
    logic [2:0] gl;
    logic       f;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  ac_motor_gate_dead_time #(.DEAD_CYCLES(D), .CNT_W(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .sector   (sector),
    .u0       (u0),
    .u1       (u1),
    .u2       (u2),
    .u7       (u7),
    .fault_clr(fault_clr),
    .gate_h   (gate_h),
    .gate_l   (gate_l),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  // Shoot-through monitor, sampled mid-cycle.
  always @(negedge clk) begin
    n_vec++;
    if ((gate_h & gate_l) != 3'b000) begin
      n_err++;
      $display("FAIL overlap: gate_h=%b gate_l=%b required no common bit", gate_h, gate_l);
    end
  end

  task automatic push(input logic [2:0] gh, input logic [2:0] gl, input logic f,
                      input int n, input string tag);
    exp_t e;
    e.gh = gh; e.gl = gl; e.f = f; e.tag = tag;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic set_cmd(input logic [2:0] sec, input logic s0, input logic s1,
                         input logic s2, input logic s7);
    sector = sec; u0 = s0; u1 = s1; u2 = s2; u7 = s7;
  endtask

  task automatic test_reset;
    exp_t e;
    reset_n = 1'b0; enable = 1'b1; fault_clr = 1'b0;
    set_cmd(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(3'b000, 3'b000, 1'b0, 3, "reset_hold");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
  endtask

  task automatic test_startup;
    exp_t e;
    reset_n = 1'b1;
    push(3'b000, 3'b000, 1'b0, D, "startup_dead");
    push(3'b000, 3'b111, 1'b0, 2, "startup_low");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
  endtask

  task automatic test_active_vector;
    exp_t e;
    set_cmd(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(3'b000, 3'b110, 1'b0, D, "u1_s0_dead");
    push(3'b001, 3'b110, 1'b0, 2, "u1_s0_high");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    set_cmd(3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    push(3'b000, 3'b100, 1'b0, D, "u1_s2_dead");
    push(3'b010, 3'b101, 1'b0, 2, "u1_s2_b_high");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
    set_cmd(3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    push(3'b000, 3'b100, 1'b0, D, "u2_s5_dead");
    push(3'b001, 3'b110, 1'b0, 2, "u2_s5_wrap");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
  endtask

  task automatic test_revert;
    exp_t e;
    set_cmd(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(3'b000, 3'b110, 1'b0, 2, "revert_enter");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
    set_cmd(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(3'b000, 3'b110, 1'b0, D, "revert_reload");
    push(3'b001, 3'b110, 1'b0, 2, "revert_high");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
  endtask

  // kind 0: two strobes at once; kind 1: sector 7. Starts and ends with A high, B/C low.
  task automatic test_fault(input int kind);
    exp_t e;
    if (kind == 0) set_cmd(3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    else           set_cmd(3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    push(3'b000, 3'b000, 1'b1, 2, kind == 0 ? "fault_u1u2" : "fault_s7");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
    set_cmd(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef AC_MOTOR_GATE_FAULT_LATCH_EN
    push(3'b000, 3'b000, 1'b1, 3, "fault_latched");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
    fault_clr = 1'b1;
    push(3'b000, 3'b000, 1'b0, 1, "fault_clear_edge");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
    fault_clr = 1'b0;
    push(3'b000, 3'b000, 1'b0, D - 1, "fault_restart_dead");
`else
    fault_clr = 1'b1;
    push(3'b000, 3'b000, 1'b0, D, "fault_auto_dead");
`endif
    push(3'b001, 3'b110, 1'b0, 2, "fault_recovered");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      fault_clr = 1'b0;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
  endtask

  task automatic test_enable_drop;
    exp_t e;
    set_cmd(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(3'b000, 3'b110, 1'b0, 2, "en_pre_dead");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
    enable = 1'b0;
    push(3'b000, 3'b000, 1'b0, 2, "en_low_off");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
    enable = 1'b1;
    push(3'b000, 3'b000, 1'b0, D, "reen_dead");
    push(3'b000, 3'b111, 1'b0, 2, "reen_low");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    set_cmd(3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    push(3'b000, 3'b000, 1'b0, 1, "async_reset");
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
      n_err++;
      $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
               e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
    end
    @(negedge clk);
    reset_n = 1'b1;
    push(3'b000, 3'b000, 1'b0, D, "rel_mid_dead");
    push(3'b110, 3'b001, 1'b0, 2, "rel_mid_s3");
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({gate_h, gate_l, fault} !== {e.gh, e.gl, e.f}) begin
        n_err++;
        $display("FAIL %s: got h=%b l=%b f=%b want h=%b l=%b f=%b",
                 e.tag, gate_h, gate_l, fault, e.gh, e.gl, e.f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_active_vector();
    test_wrap();
    test_revert();
    test_fault(0);
    test_fault(1);
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
